// File: rtl/sem_byte_serializer_if.sv
// Handshake bundle between the word source, the serializer and the
// semaphore mailbox connector on side A.
interface sem_byte_serializer_if #(
  parameter int WIDTH = 8
);
  logic             byte_valid_i;
  logic [WIDTH-1:0] byte_data_i;
  logic             byte_ready_o;
  logic             sema_is_empty_i_s_A;
  logic             sema_write_o_s_A;
  logic             sema_data_o_s_A;
  logic             busy_o;

  // Serializer view.
  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    input  sema_is_empty_i_s_A,
    output byte_ready_o,
    output sema_write_o_s_A,
    output sema_data_o_s_A,
    output busy_o
  );

  // Word source / connector view.
  modport master (
    output byte_valid_i,
    output byte_data_i,
    output sema_is_empty_i_s_A,
    input  byte_ready_o,
    input  sema_write_o_s_A,
    input  sema_data_o_s_A,
    input  busy_o
  );
endinterface

// File: rtl/sem_byte_serializer.sv
// Side-A producer: frames a parallel word (start bit, data bits, optional
// even parity) and pushes it one bit per mailbox slot, writing only when the
// connector reports the slot empty.
//
//  state  | meaning
//  IDLE   | ready for a word, no frame in progress
//  START  | sending the start bit (always 1)
//  DATA   | sending data bit bit_cnt in MSB_FIRST order
//  PARITY | sending the even-parity bit
module sem_byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk_s,
  input  logic                 rst_s,
  sem_byte_serializer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             write_q;
  logic             data_q;

  logic             sending;
  logic             accept;
  logic             fire;
  logic             cur_bit;
  logic             last_data;

  // write_q doubles as the guard: the connector's empty flag is stale during
  // the write cycle, so the strobe cycle itself is never a decision cycle.
  // The bit is retired at the edge that ends the strobe cycle.
  assign accept    = bus.byte_valid_i && (state == IDLE);
  assign fire      = sending && !write_q && bus.sema_is_empty_i_s_A;
  assign last_data = (bit_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk_s) begin
    if (rst_s) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: advance only when the current bit's strobe cycle ends.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept)  state_nxt = START;
      START:  if (write_q) state_nxt = DATA;
      DATA:   if (write_q && last_data) state_nxt = PARITY_EN ? PARITY : IDLE;
      PARITY: if (write_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and the bit currently on offer.
  always_comb begin
    sending          = (state != IDLE);
    bus.byte_ready_o = (state == IDLE) && !rst_s;
    bus.busy_o       = sending;
    bus.sema_write_o_s_A = write_q;
    bus.sema_data_o_s_A  = data_q;
    cur_bit = 1'b0;
    case (state)
      START:   cur_bit = 1'b1;
      DATA:    cur_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
      PARITY:  cur_bit = par_q;
      default: cur_bit = 1'b0;
    endcase
  end

  // Datapath: capture, registered strobe/data, shift and bit count.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      write_q <= 1'b0;
      data_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      write_q <= fire;
      if (fire) data_q <= cur_bit;
      if (accept) begin
        shift_q <= bus.byte_data_i;
        par_q   <= ^bus.byte_data_i;
        bit_cnt <= '0;
      end else if ((state == DATA) && write_q) begin
        shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bit_cnt <= last_data ? '0 : bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
